// File: rtl/router_src_arbiter.sv
// Round-robin packet arbiter feeding the router input port from three sources.
// Frames each packet from the header length and appends the XOR parity byte.
module router_src_arbiter #(
    parameter int N_SRC = 3,
    parameter int DW    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [N_SRC*DW-1:0] src_data,
    output logic [N_SRC-1:0]   src_ready,
    input  logic               busy,
    output logic [DW-1:0]      data_in,
    output logic               pkt_valid,
    output logic               grant_vld,
    output logic [1:0]         grant_id,
    output logic               pkt_done,
    output logic               underrun
);

    localparam int LW = DW - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      last_q, last_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   parity_q, parity_d;
    logic            grant_vld_q, grant_vld_d;
    logic            pkt_done_q, pkt_done_d;
    logic            underrun_q, underrun_d;

    logic [DW-1:0]    src_byte;
    logic             src_vld_g;
    logic [N_SRC-1:0] grant_oh;
    logic [DW-1:0]    pay_byte;
    logic [LW-1:0]    hdr_len;
    logic             rr_found;
    logic [1:0]       rr_pick;

    // Select the owning source's byte and valid.
    always_comb begin
        src_byte  = '0;
        src_vld_g = 1'b0;
        grant_oh  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (int'(grant_q) == i) begin
                src_byte    = src_data[i*DW +: DW];
                src_vld_g   = src_valid[i];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // A missing payload byte is forwarded as zero so the router framing stays intact.
    assign pay_byte = src_vld_g ? src_byte : '0;
    assign hdr_len  = src_byte[DW-1:2];

    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_pick  = 2'd0;
        idx      = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last_q) + k) % N_SRC;
            if (!rr_found && src_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = 2'(idx);
            end
        end
    end

    always_comb begin
        data_in   = '0;
        pkt_valid = 1'b0;
        src_ready = '0;
        case (state_q)
            S_HEADER: begin
                data_in   = src_byte;
                pkt_valid = 1'b1;
                if (!busy && src_vld_g) src_ready = grant_oh;
            end
            S_PAYLOAD: begin
                data_in   = pay_byte;
                pkt_valid = 1'b1;
                if (!busy && src_vld_g) src_ready = grant_oh;
            end
            S_PARITY: begin
                data_in = parity_q;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        grant_vld_d = grant_vld_q;
        pkt_done_d  = 1'b0;
        underrun_d  = underrun_q;
        case (state_q)
            S_IDLE: begin
                if (!busy && rr_found) begin
                    grant_d     = rr_pick;
                    grant_vld_d = 1'b1;
                    state_d     = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!busy && src_vld_g) begin
                    parity_d = src_byte;
                    cnt_d    = hdr_len;
                    state_d  = (hdr_len != '0) ? S_PAYLOAD : S_PARITY;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ pay_byte;
                    cnt_d    = cnt_q - LW'(1);
                    if (!src_vld_g) underrun_d = 1'b1;
                    if (cnt_q == LW'(1)) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    pkt_done_d  = 1'b1;
                    last_d      = grant_q;
                    grant_vld_d = 1'b0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'd0;
            last_q      <= 2'd2;
            cnt_q       <= '0;
            parity_q    <= '0;
            grant_vld_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            grant_vld_q <= grant_vld_d;
            pkt_done_q  <= pkt_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign grant_vld = grant_vld_q;
    assign grant_id  = grant_q;
    assign pkt_done  = pkt_done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_router_src_arbiter.sv
// Directed bench for router_src_arbiter: byte-queue sources and a router-side log.
module tb_router_src_arbiter;

    localparam int N_SRC = 3;
    localparam int DW    = 8;

    logic               clock;
    logic               reset;
    logic [N_SRC-1:0]   src_valid;
    logic [N_SRC*DW-1:0] src_data;
    logic [N_SRC-1:0]   src_ready;
    logic               busy;
    logic [DW-1:0]      data_in;
    logic               pkt_valid;
    logic               grant_vld;
    logic [1:0]         grant_id;
    logic               pkt_done;
    logic               underrun;

    router_src_arbiter #(.N_SRC(N_SRC), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .busy      (busy),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .pkt_done  (pkt_done),
        .underrun  (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [2:0] drop;
    logic [7:0] log_d[$];
    logic       log_pv[$];

    logic [7:0] s_data;
    logic       s_pv, s_gv, s_done, s_under;
    logic [2:0] s_rdy;
    logic [1:0] s_gid;

    int n_checks, n_pass, rdy_pulses, done_pulses;

    task automatic drive();
        src_valid[0]   = (q0.size() > 0) && !drop[0];
        src_valid[1]   = (q1.size() > 0) && !drop[1];
        src_valid[2]   = (q2.size() > 0) && !drop[2];
        src_data[7:0]   = (q0.size() > 0) ? q0[0] : 8'h00;
        src_data[15:8]  = (q1.size() > 0) ? q1[0] : 8'h00;
        src_data[23:16] = (q2.size() > 0) ? q2[0] : 8'h00;
    endtask

    // One clock: drive, sample at negedge, consume accepted bytes at posedge.
    task automatic step();
        drive();
        @(negedge clock);
        s_data  = data_in;
        s_pv    = pkt_valid;
        s_gv    = grant_vld;
        s_done  = pkt_done;
        s_under = underrun;
        s_rdy   = src_ready;
        s_gid   = grant_id;
        if (grant_vld && !busy) begin
            log_d.push_back(data_in);
            log_pv.push_back(pkt_valid);
        end
        rdy_pulses += $countones(src_ready);
        if (pkt_done) done_pulses++;
        @(posedge clock);
        if (s_rdy[0] && q0.size() > 0) void'(q0.pop_front());
        if (s_rdy[1] && q1.size() > 0) void'(q1.pop_front());
        if (s_rdy[2] && q2.size() > 0) void'(q2.pop_front());
        #1;
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_pv.delete();
        rdy_pulses  = 0;
        done_pulses = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        busy  = 1'b0;
        drop  = '0;
        q0.delete();
        q1.delete();
        q2.delete();
        drive();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    function automatic int log_mismatch(input logic [7:0] ed[$], input logic ep[$]);
        if (ed.size() != log_d.size()) return -2;
        for (int i = 0; i < ed.size(); i++)
            if (log_d[i] !== ed[i] || log_pv[i] !== ep[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        busy  = 1'b0;
        drop  = '0;
        drive();
        #2;
        n_checks++; if (data_in !== 8'h00) $display("FAIL reset_data_in: got %h want 00", data_in); else n_pass++;
        n_checks++; if (pkt_valid !== 1'b0) $display("FAIL reset_pkt_valid: got %b want 0", pkt_valid); else n_pass++;
        n_checks++; if (src_ready !== 3'b000) $display("FAIL reset_src_ready: got %b want 000", src_ready); else n_pass++;
        n_checks++; if (grant_vld !== 1'b0) $display("FAIL reset_grant_vld: got %b want 0", grant_vld); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (pkt_done !== 1'b0) $display("FAIL reset_pkt_done: got %b want 0", pkt_done); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (s_gv !== 1'b0) $display("FAIL idle_no_grant: grant_vld got %b want 0", s_gv); else n_pass++;
    endtask

    task automatic test_single_src1();
        logic [7:0] ed[$];
        logic       ep[$];
        int done_at, m;
        logic [1:0] gid_seen;
        clear_logs();
        done_at  = 0;
        gid_seen = 2'd3;
        q1 = '{8'h16, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 1; k <= 30; k++) begin
            step();
            if (s_gv) gid_seen = s_gid;
            if (s_done && done_at == 0) done_at = k;
            if (done_at != 0 && k >= done_at + 2) break;
        end
        ed = '{8'h16, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h07};
        ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        m = log_mismatch(ed, ep);
        n_checks++; if (done_at != 9) $display("FAIL single_cycles: pkt_done at cycle %0d want 9 (0 = timeout)", done_at); else n_pass++;
        n_checks++; if (done_pulses != 1) $display("FAIL single_done_pulses: got %0d want 1", done_pulses); else n_pass++;
        n_checks++; if (gid_seen !== 2'd1) $display("FAIL single_grant_id: got %0d want 1", gid_seen); else n_pass++;
        n_checks++; if (m != -1) $display("FAIL single_log: idx %0d got %p/%p want %p/%p", m, log_d, log_pv, ed, ep); else n_pass++;
        n_checks++; if (rdy_pulses != 6) $display("FAIL single_ready_pulses: got %0d want 6", rdy_pulses); else n_pass++;
        n_checks++; if (s_under !== 1'b0) $display("FAIL single_underrun: got %b want 0", s_under); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] ed[$];
        logic       ep[$];
        int order[$];
        int dones[$];
        int exp_order[$];
        int exp_dones[$];
        logic prev_gv;
        int m;
        do_reset();
        clear_logs();
        prev_gv = 1'b0;
        q0 = '{8'h04, 8'hA0, 8'h04, 8'hA3};
        q1 = '{8'h05, 8'hB1};
        q2 = '{8'h06, 8'hC2};
        for (int k = 1; k <= 40; k++) begin
            step();
            if (s_gv && !prev_gv) order.push_back(int'(s_gid));
            prev_gv = s_gv;
            if (s_done) dones.push_back(k);
            if (dones.size() == 4 && k >= dones[3] + 1) break;
        end
        exp_order = '{0, 1, 2, 0};
        exp_dones = '{5, 10, 15, 20};
        ed = '{8'h04, 8'hA0, 8'hA4, 8'h05, 8'hB1, 8'hB4, 8'h06, 8'hC2, 8'hC4, 8'h04, 8'hA3, 8'hA7};
        ep = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        m = log_mismatch(ed, ep);
        n_checks++; if (order != exp_order) $display("FAIL rr_order: got %p want %p", order, exp_order); else n_pass++;
        n_checks++; if (dones != exp_dones) $display("FAIL rr_done_cycles: got %p want %p", dones, exp_dones); else n_pass++;
        n_checks++; if (m != -1) $display("FAIL rr_log: idx %0d got %p/%p want %p/%p", m, log_d, log_pv, ed, ep); else n_pass++;
        n_checks++; if (s_under !== 1'b0) $display("FAIL rr_underrun: got %b want 0", s_under); else n_pass++;
    endtask

    task automatic test_busy_payload();
        logic [7:0] ed[$];
        logic       ep[$];
        int done_at, busy_rdy, m;
        logic held_bad;
        clear_logs();
        done_at  = 0;
        busy_rdy = 0;
        held_bad = 1'b0;
        q2.push_back(8'h38);
        for (int b = 1; b <= 14; b++) q2.push_back(8'(b));
        for (int k = 1; k <= 40; k++) begin
            busy = (k >= 4 && k <= 6);
            step();
            if (k >= 4 && k <= 6) begin
                busy_rdy += $countones(s_rdy);
                if (s_data !== 8'h02 || s_pv !== 1'b1) held_bad = 1'b1;
            end
            if (s_done && done_at == 0) done_at = k;
            if (done_at != 0 && k >= done_at + 1) break;
        end
        busy = 1'b0;
        ed.push_back(8'h38);
        ep.push_back(1'b1);
        for (int b = 1; b <= 14; b++) begin
            ed.push_back(8'(b));
            ep.push_back(1'b1);
        end
        ed.push_back(8'h37);
        ep.push_back(1'b0);
        m = log_mismatch(ed, ep);
        n_checks++; if (done_at != 21) $display("FAIL busy_cycles: pkt_done at cycle %0d want 21 (0 = timeout)", done_at); else n_pass++;
        n_checks++; if (busy_rdy != 0) $display("FAIL busy_ready_low: got %0d pulses want 0", busy_rdy); else n_pass++;
        n_checks++; if (held_bad !== 1'b0) $display("FAIL busy_data_held: got bad=%b want data 02 held", held_bad); else n_pass++;
        n_checks++; if (m != -1) $display("FAIL busy_log: idx %0d got %p want %p", m, log_d, ed); else n_pass++;
        n_checks++; if (rdy_pulses != 15) $display("FAIL busy_ready_pulses: got %0d want 15", rdy_pulses); else n_pass++;
    endtask

    task automatic test_len0();
        logic [7:0] ed[$];
        logic       ep[$];
        int done_at, m;
        clear_logs();
        done_at = 0;
        q0 = '{8'h01};
        for (int k = 1; k <= 20; k++) begin
            step();
            if (s_done && done_at == 0) done_at = k;
            if (done_at != 0 && k >= done_at + 1) break;
        end
        ed = '{8'h01, 8'h01};
        ep = '{1'b1, 1'b0};
        m = log_mismatch(ed, ep);
        n_checks++; if (done_at != 4) $display("FAIL len0_cycles: pkt_done at cycle %0d want 4 (0 = timeout)", done_at); else n_pass++;
        n_checks++; if (m != -1) $display("FAIL len0_log: idx %0d got %p/%p want %p/%p", m, log_d, log_pv, ed, ep); else n_pass++;
        n_checks++; if (rdy_pulses != 1) $display("FAIL len0_ready_pulses: got %0d want 1", rdy_pulses); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [7:0] ed[$];
        logic       ep[$];
        int done_at, m;
        logic under_before;
        clear_logs();
        done_at      = 0;
        under_before = 1'bx;
        q1 = '{8'h0C, 8'h5A, 8'h6B, 8'h7C};
        for (int k = 1; k <= 20; k++) begin
            drop = (k == 4) ? 3'b010 : 3'b000;
            step();
            if (k == 4) under_before = s_under;
            if (s_done && done_at == 0) begin
                done_at = k;
                q1.delete();
            end
            if (done_at != 0 && k >= done_at + 1) break;
        end
        drop = '0;
        ed = '{8'h0C, 8'h5A, 8'h00, 8'h6B, 8'h3D};
        ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        m = log_mismatch(ed, ep);
        n_checks++; if (under_before !== 1'b0) $display("FAIL underrun_before: got %b want 0", under_before); else n_pass++;
        n_checks++; if (done_at != 7) $display("FAIL underrun_cycles: pkt_done at cycle %0d want 7 (0 = timeout)", done_at); else n_pass++;
        n_checks++; if (m != -1) $display("FAIL underrun_log: idx %0d got %p/%p want %p/%p", m, log_d, log_pv, ed, ep); else n_pass++;
        n_checks++; if (rdy_pulses != 3) $display("FAIL underrun_ready_pulses: got %0d want 3", rdy_pulses); else n_pass++;
        n_checks++; if (s_under !== 1'b1) $display("FAIL underrun_set: got %b want 1", s_under); else n_pass++;
        for (int k = 0; k < 5; k++) step();
        n_checks++; if (s_under !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", s_under); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] gid_first;
        logic       got_grant;
        clear_logs();
        q1 = '{8'h14, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int k = 1; k <= 4; k++) step();
        n_checks++; if (s_gv !== 1'b1 || s_gid !== 2'd1) $display("FAIL mid_owned: gv=%b id=%0d want 1/1", s_gv, s_gid); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (data_in !== 8'h00) $display("FAIL mid_reset_data_in: got %h want 00", data_in); else n_pass++;
        n_checks++; if (pkt_valid !== 1'b0) $display("FAIL mid_reset_pkt_valid: got %b want 0", pkt_valid); else n_pass++;
        n_checks++; if (src_ready !== 3'b000) $display("FAIL mid_reset_src_ready: got %b want 000", src_ready); else n_pass++;
        n_checks++; if (grant_vld !== 1'b0 || grant_id !== 2'd0) $display("FAIL mid_reset_grant: gv=%b id=%0d want 0/0", grant_vld, grant_id); else n_pass++;
        n_checks++; if (pkt_done !== 1'b0) $display("FAIL mid_reset_pkt_done: got %b want 0", pkt_done); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL mid_reset_underrun: got %b want 0", underrun); else n_pass++;
        q1.delete();
        drive();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        clear_logs();
        got_grant = 1'b0;
        gid_first = 2'd3;
        q0 = '{8'h01};
        q2 = '{8'h02};
        for (int k = 1; k <= 20; k++) begin
            step();
            if (s_gv && !got_grant) begin
                got_grant = 1'b1;
                gid_first = s_gid;
            end
            if (done_pulses == 2) break;
        end
        n_checks++; if (gid_first !== 2'd0) $display("FAIL mid_next_grant: got %0d want 0", gid_first); else n_pass++;
        n_checks++; if (done_pulses != 2) $display("FAIL mid_after_packets: got %0d done pulses want 2", done_pulses); else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        busy      = 1'b0;
        drop      = '0;
        src_valid = '0;
        src_data  = '0;
        test_reset();
        test_single_src1();
        test_round_robin();
        test_busy_payload();
        test_len0();
        test_underrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
